// File: rtl/div4_pair_packer.sv
// -----------------------------------------------------------------------------
// div4_pair_packer
//
// Packs the byte stream coming out of the divide-by-4 byte stage into 16-bit
// words, first byte in the high half. If a lone byte stays unpaired for
// FLUSH_GAP idle cycles, it is flushed with a zero low byte and marked partial.
// Words go into a show-ahead FIFO that is read with a valid/ready handshake.
//
// Parameters
//   DEPTH      FIFO entries (power of 2, >= 2)
//   FLUSH_GAP  idle cycles after a lone held byte before it is flushed (>= 1)
//
// Ports
//   CLKin        in   clock, rising edge
//   reset        in   asynchronous active-low reset
//   data_in      in   [7:0]  byte from the divide-by-4 stage
//   data_valid   in   data_in valid this cycle (no backpressure)
//   out_data     out  [15:0] FIFO head word {first_byte, second_byte}
//   out_partial  out  head word was flushed; low byte is pad 8'h00
//   out_valid    out  FIFO not empty
//   out_ready    in   consumer takes the head word this cycle
//   fifo_count   out  [clog2(DEPTH):0] entries stored
//   overflow     out  sticky: a word was dropped because the FIFO was full
//
// Optional feature (macro DIV4_PACK_STATS_EN)
//   word_cnt     out  [15:0] successfully pushed words, saturating
//   partial_cnt  out  [15:0] successfully pushed flush words, saturating
// -----------------------------------------------------------------------------
module div4_pair_packer #(
    parameter int DEPTH     = 4,
    parameter int FLUSH_GAP = 3
) (
    input  logic                     CLKin,
    input  logic                     reset,
    input  logic [7:0]               data_in,
    input  logic                     data_valid,
    output logic [15:0]              out_data,
    output logic                     out_partial,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow
`ifdef DIV4_PACK_STATS_EN
    ,
    output logic [15:0]              word_cnt,
    output logic [15:0]              partial_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = $clog2(FLUSH_GAP + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(FLUSH_GAP - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t          state_q;
    logic [7:0]      held_q;
    logic [GW-1:0]   gap_q;

    logic [16:0]     mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic            overflow_q;

    logic            push_d;
    logic [16:0]     push_entry_d;
    logic            do_pop, do_wr, full;

    // ---- packing FSM: decides this cycle's push ----
    // The push fires on the same edge that completes the pair or expires the
    // gap, so it is decoded combinationally from the registered state.
    always_comb begin
        push_d       = 1'b0;
        push_entry_d = {1'b0, held_q, data_in};
        if (state_q == HOLD) begin
            if (data_valid) begin
                push_d       = 1'b1;
                push_entry_d = {1'b0, held_q, data_in};
            end else if (gap_q == GAP_LAST) begin
                push_d       = 1'b1;
                push_entry_d = {1'b1, held_q, 8'h00};
            end
        end
    end

    always_ff @(posedge CLKin or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            held_q  <= '0;
            gap_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (data_valid) begin
                        held_q  <= data_in;
                        gap_q   <= '0;
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (data_valid || gap_q == GAP_LAST) begin
                        gap_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        gap_q <= gap_q + GW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // ---- show-ahead FIFO ----
    // A pop on the same edge frees a slot, so a push into a full FIFO that is
    // being read is still accepted.
    assign full   = (count_q == FULL_CNT);
    assign do_pop = out_valid && out_ready;
    assign do_wr  = push_d && (!full || do_pop);

    always_comb begin
        count_d = count_q + CW'(do_wr) - CW'(do_pop);
    end

    always_ff @(posedge CLKin or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            count_q <= count_d;
            if (do_wr)  wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push_d && !do_wr) overflow_q <= 1'b1;
        end
    end

    // Storage carries data only; validity comes from the pointers/count.
    always_ff @(posedge CLKin) begin
        if (do_wr) mem_q[wr_ptr_q] <= push_entry_d;
    end

    assign out_valid  = (count_q != '0);
    assign fifo_count = count_q;
    assign overflow   = overflow_q;

    // Gate the head so the outputs read zero when nothing is stored.
    assign {out_partial, out_data} = out_valid ? mem_q[rd_ptr_q] : 17'd0;

`ifdef DIV4_PACK_STATS_EN
    // ---- statistics ----
    logic [15:0] word_cnt_q, partial_cnt_q;

    always_ff @(posedge CLKin or negedge reset) begin
        if (!reset) begin
            word_cnt_q    <= '0;
            partial_cnt_q <= '0;
        end else if (do_wr) begin
            word_cnt_q <= sat_inc(word_cnt_q);
            if (push_entry_d[16]) partial_cnt_q <= sat_inc(partial_cnt_q);
        end
    end

    assign word_cnt    = word_cnt_q;
    assign partial_cnt = partial_cnt_q;
`endif

endmodule

// File: doc/div4_pair_packer.md
Name: div4_pair_packer

Overview:
Downstream consumer of the divide-by-4 byte stage. Takes its byte stream (data_in/data_valid, no backpressure) and packs consecutive valid bytes into 16-bit words, first byte in the high half. Odd trailing bytes are flushed zero-padded after an idle gap. Words are buffered in a small show-ahead FIFO with a valid/ready output handshake.

Parameters:
DEPTH, 4, FIFO entries; power of 2, >= 2.
FLUSH_GAP, 3, idle cycles (data_valid low) after a lone held byte before it is flushed; >= 1.

Ports:
CLKin  input  1  clock, rising edge.
reset  input  1  asynchronous, active-low reset.
data_in  input  8  byte from the divide-by-4 stage.
data_valid  input  1  data_in is valid this cycle; no backpressure.
out_data  output  16  FIFO head word {first_byte, second_byte}.
out_partial  output  1  head word was flushed; low byte is pad 8'h00.
out_valid  output  1  FIFO not empty.
out_ready  input  1  consumer accepts the head word this cycle.
fifo_count  output  clog2(DEPTH)+1  entries currently stored.
overflow  output  1  sticky; a word was dropped because the FIFO was full.

Behaviour:
- Reset (reset low, async) clears state to IDLE, clears the held byte, gap counter, FIFO pointers and overflow. Outputs during reset: out_valid=0, fifo_count=0, overflow=0, out_data=0, out_partial=0. A held byte is discarded.
- FSM IDLE: data_valid=1 latches data_in as the held byte, clears gap_cnt, and moves to HOLD.
- FSM HOLD, data_valid=1: push {held, data_in} with partial=0, then go to IDLE.
- FSM HOLD, data_valid=0: gap_cnt increments. When gap_cnt reaches FLUSH_GAP, push {held, 8'h00} with partial=1, then go to IDLE.
- Flush timing: byte held at edge N, data_valid low at edges N+1..N+FLUSH_GAP, push at edge N+FLUSH_GAP.
- Pairing is strictly positional. A new valid byte in HOLD always completes the pair, whatever the gap_cnt value below FLUSH_GAP.
- Latency: a word pushed at edge N gives out_valid=1 immediately after edge N.
  - out_valid = (fifo_count != 0), combinational from registered state.
  - out_data/out_partial show the head entry, show-ahead.
- Pop happens at any edge with out_valid && out_ready. out_ready while empty is ignored.
- Simultaneous push and pop: both occur and fifo_count is unchanged, including when the FIFO is full (the pop frees the slot).
- Push when full without pop: the word is dropped, overflow=1 until reset. The FSM still advances as if the push succeeded.
- Pointers wrap modulo DEPTH. fifo_count ranges 0..DEPTH.
- out_data is held stable while out_valid && !out_ready.

Optional Feature:
DIV4_PACK_STATS_EN.
- Defined: adds outputs word_cnt[15:0] and partial_cnt[15:0].
  - word_cnt counts successfully pushed words (including partial ones).
  - partial_cnt counts successful flush pushes.
  - Both are reset to 0 and saturate at 16'hFFFF. Dropped words are not counted.
- Undefined: neither port nor counter exists. All other behaviour is identical.

Test Plan:
- Pair packing: reset low 50 ns then high. Bytes 8'h75, 8'h75 on consecutive cycles, out_ready=1 -> one word 16'h7575, out_partial=0, out_valid high exactly 1 cycle.
- Back-to-back pairs: bytes 81,75,41,35 contiguous, out_ready=0 -> fifo_count=2. Then raise out_ready -> words 16'h8175, 16'h4135 in order.
- Flush: single byte 8'h81 then data_valid low, FLUSH_GAP=3 -> push 3 edges after capture, out_data=16'h8100, out_partial=1. A byte arriving 2 idle cycles after 8'h81 instead pairs as 16'h81xx.
- Overflow/full: out_ready=0, push 5 pairs with DEPTH=4 -> fifo_count=4, overflow=1, first 4 words intact. Push and pop in the same cycle while full -> count stays 4, overflow unchanged.
- Reset mid-operation: assert reset with a byte held and 2 words queued -> out_valid=0, fifo_count=0 asynchronously, held byte lost. The next pair after release packs correctly.
- With DIV4_PACK_STATS_EN: after the flush and pair scenarios -> word_cnt=2, partial_cnt=1. Dropped overflow words are not counted.
